// File: rtl/datastream_analyzer_mc.sv
// rtl/datastream_analyzer_mc.sv - multi-channel run-of-equal-words analyzer with output FIFO
//
// Accepts channel-tagged words on a valid/ready handshake and tracks, per channel,
// the run length of identical consecutive words. Every accepted word is forwarded
// unchanged and in acceptance order through a FIFO. The frame flag is computed at
// acceptance and travels with the word.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous reset, active-low
//   data_i   input word            chan_i   channel id of data_i
//   valid_i  input word valid      ready_o  block can accept a word
//   data_o   FIFO head word        chan_o   channel id of data_o
//   frame_o  data_o completes a run of WINDOWSIZE equal words on chan_o
//   valid_o  output word valid     ready_i  downstream accepts output word
module datastream_analyzer_mc #(
  parameter int DATASIZE   = 8,
  parameter int WINDOWSIZE = 4,
  parameter int CHANNELS   = 4,
  parameter int FIFODEPTH  = 4,
  parameter int OVERLAP    = 0,
  parameter int ERRNO      = 0,
  localparam int CHANW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATASIZE-1:0] data_i,
  input  logic [CHANW-1:0]    chan_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [DATASIZE-1:0] data_o,
  output logic [CHANW-1:0]    chan_o,
  output logic                frame_o,
  output logic                valid_o,
  input  logic                ready_i
);

  localparam int CNTW = $clog2(WINDOWSIZE + 1);
  localparam int AW   = $clog2(FIFODEPTH);
  localparam int EW   = DATASIZE + CHANW + 1;
  localparam logic [CNTW-1:0] WIN = CNTW'(WINDOWSIZE);

  logic [DATASIZE-1:0] last_q [CHANNELS];
  logic [CNTW-1:0]     cnt_q  [CHANNELS];
  logic [EW-1:0]       mem_q  [FIFODEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;

  logic                full, push, pop, chan_legal, match, frame_in;
  logic [DATASIZE-1:0] sel_last;
  logic [CNTW-1:0]     sel_cnt, ncnt, cnt_d;
  logic [EW-1:0]       head;

  assign full    = (count_q == (AW+1)'(FIFODEPTH));
  // ready_o is forced low while reset is asserted; no bypass path when full.
  assign ready_o = rst_i & ((ERRNO == 2) ? 1'b1 : !full);
  assign valid_o = (count_q != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // Out-of-range channel ids are forwarded but never touch run state.
  assign chan_legal = (32'(chan_i) < CHANNELS);

  always_comb begin
    sel_last = '0;
    sel_cnt  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CHANW'(c) == chan_i) begin
        sel_last = last_q[c];
        sel_cnt  = cnt_q[c];
      end
    end
  end

  // cnt==0 means "no run yet", so a first word never matches a reset last value.
  assign match    = (sel_cnt != '0) && (data_i == sel_last);
  assign ncnt     = !match ? CNTW'(1) :
                    (sel_cnt == WIN) ? WIN : CNTW'(sel_cnt + 1'b1);
  // Saturated counts (OVERLAP=1) keep ncnt at WIN, so one compare covers both modes.
  assign frame_in = chan_legal && (ncnt == WIN);
  assign cnt_d    = frame_in ? (((OVERLAP != 0) || (ERRNO == 1)) ? WIN : '0) : ncnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        last_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (chan_legal && (CHANW'(c) == chan_i)) begin
            last_q[c] <= data_i;
            cnt_q[c]  <= cnt_d;
          end
        end
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {frame_in, chan_i, data_i};
  end

  assign head    = mem_q[rd_ptr_q];
  assign data_o  = valid_o ? head[DATASIZE-1:0] : '0;
  assign chan_o  = valid_o ? head[DATASIZE +: CHANW] : '0;
  assign frame_o = valid_o & head[EW-1];

endmodule

// File: tb/tb_datastream_analyzer_mc.sv
// tb/tb_datastream_analyzer_mc.sv - directed self-checking bench for datastream_analyzer_mc
module tb_datastream_analyzer_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic [1:0] chan_i;
  logic       valid_i;
  logic       ready_i;

  logic       ready_o, valid_o, frame_o;
  logic [7:0] data_o;
  logic [1:0] chan_o;
  logic       o_ready, o_valid, o_frame;
  logic [7:0] o_data;
  logic [1:0] o_chan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datastream_analyzer_mc #(
    .DATASIZE(8), .WINDOWSIZE(4), .CHANNELS(3), .FIFODEPTH(4), .OVERLAP(0), .ERRNO(0)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_n), .data_i(data_i), .chan_i(chan_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .chan_o(chan_o), .frame_o(frame_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  datastream_analyzer_mc #(
    .DATASIZE(8), .WINDOWSIZE(4), .CHANNELS(3), .FIFODEPTH(4), .OVERLAP(1), .ERRNO(0)
  ) u_ovl (
    .clk_i(clk), .rst_i(rst_n), .data_i(data_i), .chan_i(chan_i), .valid_i(valid_i),
    .ready_o(o_ready), .data_o(o_data), .chan_o(o_chan), .frame_o(o_frame),
    .valid_o(o_valid), .ready_i(ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One word per cycle with ready_i=1: word shows at the output right after its accept edge.
  task automatic send(input string tag, input logic [7:0] d, input logic [1:0] c,
                      input logic ef, input logic eo);
    @(negedge clk);
    data_i = d; chan_i = c; valid_i = 1'b1;
    chk({tag, "/ready"}, 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk({tag, "/out"}, 32'({valid_o, data_o, chan_o}), 32'({1'b1, d, c}));
    chk({tag, "/frame"}, 32'(frame_o), 32'(ef));
    chk({tag, "/ovl"}, 32'({o_ready, o_valid, o_data, o_chan, o_frame}),
        32'({1'b1, 1'b1, d, c, eo}));
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/idle"}, 32'({valid_o, data_o, chan_o, frame_o}), 32'd0);
  endtask

  initial begin
    // 1: reset held with valid_i high
    rst_n = 1'b0; valid_i = 1'b1; data_i = 8'd5; chan_i = 2'd0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/hold", 32'({valid_o, ready_o, o_valid, o_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; valid_i = 1'b0;
    #1;
    chk("rst/release", 32'({ready_o, valid_o}), 32'b10);
    idle("rst");

    // 2: ch0 eight 5s; OVERLAP=0 frames on 4th/8th, OVERLAP=1 on 4th..8th
    send("run1", 8'd5, 2'd0, 1'b0, 1'b0);
    send("run2", 8'd5, 2'd0, 1'b0, 1'b0);
    send("run3", 8'd5, 2'd0, 1'b0, 1'b0);
    send("run4", 8'd5, 2'd0, 1'b1, 1'b1);
    send("run5", 8'd5, 2'd0, 1'b0, 1'b1);
    send("run6", 8'd5, 2'd0, 1'b0, 1'b1);
    send("run7", 8'd5, 2'd0, 1'b0, 1'b1);
    send("run8", 8'd5, 2'd0, 1'b1, 1'b1);
    idle("run");

    // 3: interleaving; ch1 run broken by 9
    send("il1", 8'd7, 2'd0, 1'b0, 1'b0);
    send("il2", 8'd7, 2'd1, 1'b0, 1'b0);
    send("il3", 8'd7, 2'd0, 1'b0, 1'b0);
    send("il4", 8'd9, 2'd1, 1'b0, 1'b0);
    send("il5", 8'd7, 2'd0, 1'b0, 1'b0);
    send("il6", 8'd7, 2'd0, 1'b1, 1'b1);
    idle("il");

    // 4: backpressure, five ch2 words 1..5 into a 4-deep FIFO
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_i = 8'(i + 1); chan_i = 2'd2; valid_i = 1'b1;
      chk("bp/ready_fill", 32'(ready_o), 32'd1);
      @(posedge clk); #1;
    end
    chk("bp/full", 32'({ready_o, valid_o, data_o}), 32'({1'b0, 1'b1, 8'd1}));
    @(negedge clk);
    data_i = 8'd5;
    @(posedge clk); #1;
    chk("bp/stall", 32'({ready_o, data_o}), 32'({1'b0, 8'd1}));
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp/drain2", 32'({ready_o, valid_o, data_o, chan_o}), 32'({1'b1, 1'b1, 8'd2, 2'd2}));
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("bp/drain3", 32'({valid_o, data_o}), 32'({1'b1, 8'd3}));
    @(posedge clk); #1;
    chk("bp/drain4", 32'({valid_o, data_o}), 32'({1'b1, 8'd4}));
    @(posedge clk); #1;
    chk("bp/drain5", 32'({valid_o, data_o, chan_o, frame_o}), 32'({1'b1, 8'd5, 2'd2, 1'b0}));
    @(posedge clk); #1;
    chk("bp/empty", 32'({valid_o, data_o, chan_o, frame_o}), 32'd0);

    // 5: illegal channel 3 leaves ch0 partial run and ch1 run intact
    send("ill_c0a", 8'h33, 2'd0, 1'b0, 1'b0);
    send("ill_c0b", 8'h33, 2'd0, 1'b0, 1'b0);
    send("ill_c0c", 8'h33, 2'd0, 1'b0, 1'b0);
    send("ill_x1", 8'h33, 2'd3, 1'b0, 1'b0);
    send("ill_x2", 8'h33, 2'd3, 1'b0, 1'b0);
    send("ill_x3", 8'h33, 2'd3, 1'b0, 1'b0);
    send("ill_x4", 8'h33, 2'd3, 1'b0, 1'b0);
    send("ill_c0d", 8'h33, 2'd0, 1'b1, 1'b1);
    send("ill_c1a", 8'd9, 2'd1, 1'b0, 1'b0);
    send("ill_c1b", 8'd9, 2'd1, 1'b0, 1'b0);
    send("ill_c1c", 8'd9, 2'd1, 1'b1, 1'b1);
    idle("ill");

    // 6: reset mid-run discards partial run and queued word
    send("mr1", 8'hAA, 2'd0, 1'b0, 1'b0);
    send("mr2", 8'hAA, 2'd0, 1'b0, 1'b0);
    send("mr3", 8'hAA, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr/in_reset", 32'({valid_o, ready_o, data_o, frame_o}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr/release", 32'({ready_o, valid_o}), 32'b10);
    @(posedge clk); #1;
    chk("mr/no_output", 32'({valid_o, data_o}), 32'd0);
    send("pr1", 8'hAA, 2'd0, 1'b0, 1'b0);
    send("pr2", 8'hAA, 2'd0, 1'b0, 1'b0);
    send("pr3", 8'hAA, 2'd0, 1'b0, 1'b0);
    send("pr4", 8'hAA, 2'd0, 1'b1, 1'b1);
    send("pr5", 8'hAA, 2'd0, 1'b0, 1'b1);
    idle("pr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
